// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - 6502 bus controller: reset vector, VIC colour regs, RAM req/ack bridge
module cpu_bus_ctrl #(
    parameter logic [15:0] RESET_VEC  = 16'hC000,
    parameter logic [7:0]  TIMEOUT    = 8'd64,
    parameter logic [3:0]  BORDER_RST = 4'hE,
    parameter logic [3:0]  BG_RST     = 4'h6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_strobe,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        di_valid,
    output logic        rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  border_col,
    output logic [3:0]  bg_col,
    output logic        bus_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        di_valid_q, di_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]  border_q, border_d;
    logic [3:0]  bg_q, bg_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        vec_hit;
    logic        vic_hit;
    logic [5:0]  vic_idx;

    // Address decode: vector reads win over everything, then the VIC window ($D000-$D3FF)
    always_comb begin
        vec_hit = !cpu_we && (cpu_addr[15:1] == 15'h7FFE);
        vic_hit = (cpu_addr[15:10] == 6'b110100);
        vic_idx = cpu_addr[5:0];
    end

    // Next-state and output computation; local accesses finish in one cycle, RAM goes via WAIT
    always_comb begin
        state_d     = state_q;
        cpu_di_d    = cpu_di_q;
        di_valid_d  = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        border_d    = border_q;
        bg_d        = bg_q;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (cpu_strobe) begin
                    if (vec_hit) begin
                        cpu_di_d   = cpu_addr[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
                        di_valid_d = 1'b1;
                    end else if (vic_hit) begin
                        if (cpu_we) begin
                            if (vic_idx == 6'h20) border_d = cpu_do[3:0];
                            if (vic_idx == 6'h21) bg_d     = cpu_do[3:0];
                        end else begin
                            if (vic_idx == 6'h20)      cpu_di_d = {4'hF, border_q};
                            else if (vic_idx == 6'h21) cpu_di_d = {4'hF, bg_q};
                            else                       cpu_di_d = 8'hFF;
                            di_valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = S_WAIT;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_do;
                        cnt_d       = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    // An ack on the final counted cycle still completes normally
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    if (!mem_we_q) begin
                        cpu_di_d   = mem_rdata;
                        di_valid_d = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = S_IDLE;
                    cnt_d     = 8'd0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_di_d   = 8'hFF;
                        di_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; async reset drops any in-flight RAM request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cpu_di_q    <= 8'h00;
            di_valid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            border_q    <= BORDER_RST;
            bg_q        <= BG_RST;
            bus_err_q   <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cpu_di_q    <= cpu_di_d;
            di_valid_q  <= di_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            border_q    <= border_d;
            bg_q        <= bg_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_di     = cpu_di_q;
    assign di_valid   = di_valid_q;
    assign rdy        = (state_q == S_IDLE);
    assign mem_req    = (state_q == S_WAIT);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign border_col = border_q;
    assign bg_col     = bg_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - directed self-checking bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_strobe;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        di_valid;
    logic        rdy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  border_col;
    logic [3:0]  bg_col;
    logic        bus_err;

    int tests = 0;
    int fails = 0;
    int n;
    int rdy_low;

    cpu_bus_ctrl dut (
        .clk(clk), .reset(reset), .cpu_strobe(cpu_strobe), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_do(cpu_do), .cpu_di(cpu_di), .di_valid(di_valid),
        .rdy(rdy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .border_col(border_col), .bg_col(bg_col), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic we, input logic [15:0] addr, input logic [7:0] data);
        cpu_strobe = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_do     = data;
        step();
        cpu_strobe = 1'b0;
        cpu_we     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset      = 1'b0;
        cpu_strobe = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_we     = 1'b0;
        cpu_do     = 8'h00;
        mem_rdata  = 8'h00;
        mem_ack    = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_cpu_di", cpu_di, 16'h00);
        chk("rst_di_valid", di_valid, 0);
        chk("rst_rdy", rdy, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_border", border_col, 4'hE);
        chk("rst_bg", bg_col, 4'h6);
        chk("rst_bus_err", bus_err, 0);
        reset = 1'b1;
        step();

        // T1: back-to-back vector reads
        cpu_strobe = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFC;
        step();
        chk("t1_lo_data", cpu_di, 16'h00);
        chk("t1_lo_valid", di_valid, 1);
        chk("t1_lo_rdy", rdy, 1);
        cpu_addr = 16'hFFFD;
        step();
        cpu_strobe = 1'b0;
        chk("t1_hi_data", cpu_di, 16'hC0);
        chk("t1_hi_valid", di_valid, 1);
        chk("t1_hi_rdy", rdy, 1);
        chk("t1_hi_mem_req", mem_req, 0);
        step();
        chk("t1_valid_pulse", di_valid, 0);

        // T2: VIC registers and mirrors
        strobe(1'b1, 16'hD020, 8'h52);
        chk("t2_border_wr", border_col, 4'h2);
        chk("t2_wr_no_valid", di_valid, 0);
        chk("t2_wr_rdy", rdy, 1);
        strobe(1'b0, 16'hD060, 8'h00);
        chk("t2_mirror_rd", cpu_di, 16'hF2);
        chk("t2_mirror_valid", di_valid, 1);
        strobe(1'b0, 16'hD030, 8'h00);
        chk("t2_other_rd", cpu_di, 16'hFF);
        strobe(1'b1, 16'hD021, 8'h0B);
        chk("t2_bg_wr", bg_col, 4'hB);
        chk("t2_border_kept", border_col, 4'h2);
        strobe(1'b0, 16'hD3E1, 8'h00);
        chk("t2_bg_mirror_rd", cpu_di, 16'hFB);

        // T3: RAM read acked on the third WAIT cycle; strobe during WAIT ignored
        strobe(1'b0, 16'hC000, 8'h00);
        chk("t3_req_c1", mem_req, 1);
        chk("t3_rdy_c1", rdy, 0);
        chk("t3_we", mem_we, 0);
        chk("t3_addr", mem_addr, 16'hC000);
        strobe(1'b1, 16'hD020, 8'h07);
        chk("t3_req_c2", mem_req, 1);
        chk("t3_wait_strobe_ignored", border_col, 4'h2);
        mem_ack = 1'b1; mem_rdata = 8'h8D;
        chk("t3_req_c3", mem_req, 1);
        chk("t3_rdy_c3", rdy, 0);
        step();
        mem_ack = 1'b0;
        chk("t3_req_done", mem_req, 0);
        chk("t3_rdy_done", rdy, 1);
        chk("t3_data", cpu_di, 16'h8D);
        chk("t3_valid", di_valid, 1);
        chk("t3_no_err", bus_err, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t3_idle_ack_ignored", di_valid, 0);
        chk("t3_idle_ack_rdy", rdy, 1);

        // T4: write to vector address goes to RAM
        strobe(1'b1, 16'hFFFC, 8'h12);
        chk("t4_req", mem_req, 1);
        chk("t4_we", mem_we, 1);
        chk("t4_addr", mem_addr, 16'hFFFC);
        chk("t4_wdata", mem_wdata, 16'h12);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t4_req_done", mem_req, 0);
        chk("t4_no_valid", di_valid, 0);
        chk("t4_rdy", rdy, 1);

        // T5: timeout after 64 WAIT cycles, sticky error
        strobe(1'b0, 16'h0400, 8'h00);
        rdy_low = 1;
        n = 0;
        while (rdy == 1'b0 && n < 200) begin
            step();
            n++;
            if (rdy == 1'b0) rdy_low++;
        end
        chk("t5_rdy_low_cycles", 16'(rdy_low), 16'd64);
        chk("t5_rdy", rdy, 1);
        chk("t5_req", mem_req, 0);
        chk("t5_data", cpu_di, 16'hFF);
        chk("t5_valid", di_valid, 1);
        chk("t5_err", bus_err, 1);
        strobe(1'b0, 16'hFFFD, 8'h00);
        chk("t5_err_sticky", bus_err, 1);

        // T5 rerun: ack on cycle 64 wins
        do_reset();
        chk("t5b_err_cleared", bus_err, 0);
        strobe(1'b0, 16'h0400, 8'h00);
        for (int i = 0; i < 63; i++) step();
        chk("t5b_req_c64", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        step();
        mem_ack = 1'b0;
        chk("t5b_no_err", bus_err, 0);
        chk("t5b_data", cpu_di, 16'h5A);
        chk("t5b_valid", di_valid, 1);
        chk("t5b_rdy", rdy, 1);

        // T6: async reset during WAIT, late ack afterwards
        strobe(1'b0, 16'h0800, 8'h00);
        step();
        chk("t6_in_wait", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_req_async", mem_req, 0);
        chk("t6_rdy_async", rdy, 1);
        chk("t6_addr_async", mem_addr, 16'h0000);
        chk("t6_border_async", border_col, 4'hE);
        chk("t6_bg_async", bg_col, 4'h6);
        step();
        reset = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 8'h33;
        step();
        mem_ack = 1'b0;
        chk("t6_late_ack_no_valid", di_valid, 0);
        chk("t6_late_ack_data", cpu_di, 16'h00);
        step();
        chk("t6_no_reissue", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
